// File: rtl/alu_frame_ctrl.sv
// alu_frame_ctrl: unpacks 3-byte operation frames into registered ALU
// operands, waits a programmable settle time, then captures the ALU result
// and hands it downstream over a valid/ready handshake.
module alu_frame_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_cmd,
    input  logic [7:0] alu_result,
    input  logic       alu_ovr,
    output logic [8:0] res_data,
    output logic [1:0] res_cmd,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic [7:0] op_count,
    output logic [7:0] err_count
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CMD_W  = 2;
    localparam int unsigned RES_W  = DATA_W + 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        S_HDR,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_OUT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_alu_a,     w_alu_a_nxt;
    logic [DATA_W-1:0]  r_alu_b,     w_alu_b_nxt;
    logic [CMD_W-1:0]   r_alu_cmd,   w_alu_cmd_nxt;
    logic [RES_W-1:0]   r_res_data,  w_res_data_nxt;
    logic [CMD_W-1:0]   r_res_cmd,   w_res_cmd_nxt;
    logic               r_res_valid, w_res_valid_nxt;
    logic               r_in_ready,  w_in_ready_nxt;
    logic               r_busy,      w_busy_nxt;
    logic [DATA_W-1:0]  r_op_count,  w_op_count_nxt;
    logic [DATA_W-1:0]  r_err_count, w_err_count_nxt;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic               w_byte_xfer;

    // A byte moves only when we advertised readiness on the previous edge
    assign w_byte_xfer = in_valid && r_in_ready;

    // State and datapath registers; in_ready/busy are registered decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HDR;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_cmd   <= '0;
            r_res_data  <= '0;
            r_res_cmd   <= '0;
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_op_count  <= '0;
            r_err_count <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_alu_cmd   <= w_alu_cmd_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_cmd   <= w_res_cmd_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_op_count  <= w_op_count_nxt;
            r_err_count <= w_err_count_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Next-state and next-register logic for frame unpack, settle, capture and handoff
    always_comb begin
        w_state_nxt     = r_state;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_alu_cmd_nxt   = r_alu_cmd;
        w_res_data_nxt  = r_res_data;
        w_res_cmd_nxt   = r_res_cmd;
        w_res_valid_nxt = r_res_valid;
        w_op_count_nxt  = r_op_count;
        w_err_count_nxt = r_err_count;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            S_HDR: begin
                if (w_byte_xfer) begin
                    if (in_data[7]) begin
                        w_alu_cmd_nxt = in_data[CMD_W-1:0];
                        w_state_nxt   = S_GET_A;
                    end else if (r_err_count != 8'hFF) begin
                        w_err_count_nxt = r_err_count + 8'd1;
                    end
                end
            end
            S_GET_A: begin
                if (w_byte_xfer) begin
                    w_alu_a_nxt = in_data;
                    w_state_nxt = S_GET_B;
                end
            end
            S_GET_B: begin
                if (w_byte_xfer) begin
                    w_alu_b_nxt = in_data;
                    w_cnt_nxt   = CNT_W'(EXEC_CYCLES - 1);
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_res_data_nxt  = {alu_ovr, alu_result};
                    w_res_cmd_nxt   = r_alu_cmd;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_OUT;
                end
            end
            S_OUT: begin
                if (r_res_valid && res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_op_count_nxt  = r_op_count + 8'd1;
                    w_state_nxt     = S_HDR;
                end
            end
            default: begin
                w_state_nxt = S_HDR;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == S_HDR) || (w_state_nxt == S_GET_A) ||
                         (w_state_nxt == S_GET_B);
        w_busy_nxt     = (w_state_nxt != S_HDR);
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_cmd   = r_alu_cmd;
    assign res_data  = r_res_data;
    assign res_cmd   = r_res_cmd;
    assign res_valid = r_res_valid;
    assign op_count  = r_op_count;
    assign err_count = r_err_count;

endmodule
